m_divider_pipe: RTL and testbench

//  Pipelined, parametrised Mitchell logarithmic (approximate) unsigned divider with valid/ready handshake.

---
 rtl/mdiv_pkg.sv | 25 ++
 rtl/mdiv_lod_enc.sv | 33 +++
 rtl/m_divider_pipe.sv | 137 +++++++++++++
 tb/tb_m_divider_pipe.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdiv_pkg.sv
// Shared types and helpers for the Mitchell log divider pipeline.
// Optional rounding in the last stage is enabled by M_DIVIDER_ROUND_EN.
package mdiv_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int FRAC_DEF  = 8;

   function automatic int clog2w(input int w);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < w) r = i + 1;
      return r;
   endfunction

   localparam int LW = clog2w(WIDTH_DEF);
   localparam int EW = LW + 1;

   // dz: divisor was zero, xz: dividend was zero
   typedef struct packed {
      logic dz;
      logic xz;
   } flags_t;

endpackage

// File: rtl/mdiv_lod_enc.sv
// Leading-one detector: position of the leading one plus the remaining
// bits left-aligned as a WIDTH-1 bit Mitchell fraction.
module mdiv_lod_enc
   import mdiv_pkg::*;
#(
   parameter  int WIDTH = 16,
   localparam int KW    = clog2w(WIDTH)
) (
   input  logic [WIDTH-1:0] x_i,
   output logic [KW-1:0]    k_o,
   output logic [WIDTH-2:0] f_o,
   output logic             zero_o
);

   logic [WIDTH-1:0] oh;
   logic [WIDTH-1:0] masked;
   logic [KW-1:0]    sa;

   always_comb begin
      oh = '0;
      for (int i = 0; i < WIDTH; i++)
         if (x_i[i]) oh = WIDTH'(1) << i;
      k_o = '0;
      for (int i = 0; i < WIDTH; i++)
         if (oh[i]) k_o = k_o | KW'(i);
      masked = x_i & ~oh;
      sa     = KW'(WIDTH - 1) - k_o;
      f_o    = (WIDTH-1)'(masked << sa);
   end

   assign zero_o = ~|x_i;

endmodule

// File: rtl/m_divider_pipe.sv
// Three-stage Mitchell logarithmic divider, Q(WIDTH).(FRAC) result.
// Define M_DIVIDER_ROUND_EN for half-up rounding instead of truncation.
module m_divider_pipe
   import mdiv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int FRAC  = FRAC_DEF,
   localparam int QW   = WIDTH + FRAC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] X1,
   input  logic [WIDTH-1:0] X2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [QW-1:0]    res,
   output logic             div_zero
);

   localparam int KW  = clog2w(WIDTH);
   localparam int XEW = KW + 1;

   typedef struct packed {
      logic [KW-1:0]    k1;
      logic [KW-1:0]    k2;
      logic [WIDTH-2:0] f1;
      logic [WIDTH-2:0] f2;
      flags_t           fl;
   } s1_t;

   typedef struct packed {
      logic [XEW-1:0]   e;
      logic [WIDTH-2:0] m;
      flags_t           fl;
   } s2_t;

   logic adv;
   logic v1_q, v2_q, v3_q;
   s1_t  s1_d, s1_q;
   s2_t  s2_d, s2_q;
   logic [QW-1:0] res_d, res_q;
   logic          dz_d, dz_q;

   logic [KW-1:0]    k1, k2;
   logic [WIDTH-2:0] f1, f2;
   logic             z1, z2;

   assign adv      = !v3_q | out_ready;
   assign in_ready = adv;

   mdiv_lod_enc #(.WIDTH(WIDTH)) u_lod1 (
      .x_i(X1), .k_o(k1), .f_o(f1), .zero_o(z1)
   );

   mdiv_lod_enc #(.WIDTH(WIDTH)) u_lod2 (
      .x_i(X2), .k_o(k2), .f_o(f2), .zero_o(z2)
   );

   always_comb begin
      s1_d.k1    = k1;
      s1_d.k2    = k2;
      s1_d.f1    = f1;
      s1_d.f2    = f2;
      s1_d.fl.dz = z2;
      s1_d.fl.xz = z1 & ~z2;
   end

   // Modular subtraction already yields d+2^(WIDTH-1) when f1<f2.
   logic borrow;
   always_comb begin
      borrow  = s1_q.f1 < s1_q.f2;
      s2_d.m  = s1_q.f1 - s1_q.f2;
      s2_d.e  = {1'b0, s1_q.k1} - {1'b0, s1_q.k2}
              - {{(XEW-1){1'b0}}, borrow};
      s2_d.fl = s1_q.fl;
   end

   logic signed [31:0] sh;
   logic [WIDTH-1:0]   val;
   logic [WIDTH:0]     tmp;
   logic [QW-1:0]      res_t;
   logic [QW-1:0]      res_c;
`ifdef M_DIVIDER_ROUND_EN
   logic [QW:0]        sum;
`endif

   // tmp keeps one extra bit below the result: the first dropped bit.
   always_comb begin
      sh    = 32'(signed'(s2_q.e)) + FRAC - (WIDTH - 1);
      val   = {1'b1, s2_q.m};
      tmp   = '0;
      res_t = '0;
      if (sh >= 0) begin
         res_t = QW'(val) << sh;
      end else begin
         tmp   = {val, 1'b0} >> (-sh);
         res_t = QW'(tmp >> 1);
      end
`ifdef M_DIVIDER_ROUND_EN
      sum   = {1'b0, res_t} + {{QW{1'b0}}, tmp[0]};
      res_c = sum[QW] ? '1 : sum[QW-1:0];
`else
      res_c = res_t;
`endif
      dz_d  = s2_q.fl.dz;
      res_d = res_c;
      if (s2_q.fl.dz)      res_d = '1;
      else if (s2_q.fl.xz) res_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q  <= 1'b0;
         v2_q  <= 1'b0;
         v3_q  <= 1'b0;
         s1_q  <= '0;
         s2_q  <= '0;
         res_q <= '0;
         dz_q  <= 1'b0;
      end else if (adv) begin
         v1_q  <= in_valid;
         v2_q  <= v1_q;
         v3_q  <= v2_q;
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         res_q <= res_d;
         dz_q  <= dz_d;
      end
   end

   assign out_valid = v3_q;
   assign res       = res_q;
   assign div_zero  = dz_q;

endmodule

// File: tb/tb_m_divider_pipe.sv
// Self-checking bench for m_divider_pipe against a real-valued Mitchell model.
// Define M_DIVIDER_ROUND_EN to check the rounding build.
module tb_m_divider_pipe;

   localparam int W  = 16;
   localparam int F  = 8;
   localparam int QW = W + F;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b1;
   logic [W-1:0]  x1 = '0;
   logic [W-1:0]  x2 = '0;
   logic          in_ready;
   logic          out_valid;
   logic [QW-1:0] res;
   logic          div_zero;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   m_divider_pipe #(.WIDTH(W), .FRAC(F)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .X1(x1), .X2(x2),
      .out_valid(out_valid), .out_ready(out_ready),
      .res(res), .div_zero(div_zero)
   );

   function automatic int lg2(input int unsigned v);
      int r;
      r = 0;
      while ((v >> (r + 1)) != 0) r++;
      return r;
   endfunction

   // Returns {div_zero, res}: log2 X ~= k + x, quotient = 2^(k1-k2)*(1+x1-x2).
   function automatic logic [QW:0] model(input int unsigned a, input int unsigned b);
      int  ka, kb;
      real xa, xb, q, s, r;
      if (b == 0) return {1'b1, {QW{1'b1}}};
      if (a == 0) return '0;
      ka = lg2(a);
      kb = lg2(b);
      xa = real'(a) / (2.0 ** ka) - 1.0;
      xb = real'(b) / (2.0 ** kb) - 1.0;
      if (xa >= xb) q = (2.0 ** (ka - kb)) * (1.0 + xa - xb);
      else          q = (2.0 ** (ka - kb - 1)) * (2.0 + xa - xb);
      s = q * (2.0 ** F);
`ifdef M_DIVIDER_ROUND_EN
      r = $floor(s + 0.5);
`else
      r = $floor(s);
`endif
      if (r >= 2.0 ** QW) r = 2.0 ** QW - 1.0;
      return {1'b0, QW'(longint'(r))};
   endfunction

   function automatic logic [W-1:0] rnd_op();
      int unsigned v;
      v = $urandom_range(0, 65535) >> $urandom_range(0, 15);
      if ($urandom_range(0, 19) == 0) v = 0;
      return W'(v);
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      checks++;
      if (res !== '0) begin
         errors++;
         $display("FAIL reset_res got %0h want 0", res);
      end
      checks++;
      if (div_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_div_zero got %b want 0", div_zero);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
   endtask

   typedef struct {
      int unsigned   a;
      int unsigned   b;
      logic [QW-1:0] r;
      logic          dz;
   } vec_t;

   task automatic test_directed();
      vec_t v[7];
      v[0] = '{64, 8, 24'd2048, 1'b0};
      v[1] = '{100, 10, 24'd2688, 1'b0};
      v[2] = '{12, 5, 24'd640, 1'b0};
      v[3] = '{8, 3, 24'd768, 1'b0};
      v[4] = '{77, 0, 24'hFFFFFF, 1'b1};
      v[5] = '{0, 9, 24'd0, 1'b0};
`ifdef M_DIVIDER_ROUND_EN
      v[6] = '{1, 192, 24'd2, 1'b0};
`else
      v[6] = '{1, 192, 24'd1, 1'b0};
`endif
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         out_ready = 1'b1;
         in_valid = 1'b1;
         x1 = W'(v[i].a);
         x2 = W'(v[i].b);
         @(negedge clk);
         in_valid = 1'b0;
         for (int c = 0; c < 2; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL latency_early v%0d c%0d got %b want 0", i, c, out_valid);
            end
            @(negedge clk);
         end
         checks++;
         if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency_valid v%0d got %b want 1", i, out_valid);
         end
         checks++;
         if (res !== v[i].r || div_zero !== v[i].dz) begin
            errors++;
            $display("FAIL directed %0d/%0d got res %0h dz %b want res %0h dz %b",
                     v[i].a, v[i].b, res, div_zero, v[i].r, v[i].dz);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [W-1:0]  a[5];
      logic [W-1:0]  b[5];
      logic [QW:0]   exp[5];
      logic [QW-1:0] held;
      int issued, got, hold_cnt;
      bit first_seen;
      issued = 0;
      got = 0;
      hold_cnt = 0;
      first_seen = 0;
      held = '0;
      for (int i = 0; i < 5; i++) begin
         a[i] = rnd_op();
         b[i] = W'($urandom_range(1, 65535));
         exp[i] = model(a[i], b[i]);
      end
      for (int cyc = 0; cyc < 60 && got < 5; cyc++) begin
         @(negedge clk);
         if (out_valid && !first_seen) begin
            first_seen = 1;
            held = res;
         end
         out_ready = !(first_seen && hold_cnt < 4);
         in_valid = issued < 5;
         if (issued < 5) begin
            x1 = a[issued];
            x2 = b[issued];
         end
         #1;
         if (!out_ready) begin
            hold_cnt++;
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b_in_ready got %b want 0", in_ready);
            end
            checks++;
            if (res !== held || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL b2b_hold got res %0h v %b want res %0h v 1",
                        res, out_valid, held);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if ({div_zero, res} !== exp[got]) begin
               errors++;
               $display("FAIL b2b_order idx %0d got %0h want %0h",
                        got, {div_zero, res}, exp[got]);
            end
            got++;
         end
         if (in_valid && in_ready) issued++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (got != 5) begin
         errors++;
         $display("FAIL b2b_count got %0d want 5", got);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL b2b_extra got out_valid %b want 0", out_valid);
      end
   endtask

   task automatic test_random();
      localparam int N = 400;
      logic [QW:0] q[$];
      logic [QW:0] e;
      int issued;
      issued = 0;
      for (int cyc = 0; cyc < 5000 && (issued < N || q.size() > 0); cyc++) begin
         @(negedge clk);
         out_ready = $urandom_range(0, 9) < 7;
         in_valid = (issued < N) && ($urandom_range(0, 9) < 8);
         x1 = rnd_op();
         x2 = rnd_op();
         #1;
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rand_spurious got %0h want no beat", {div_zero, res});
            end else begin
               e = q.pop_front();
               if ({div_zero, res} !== e) begin
                  errors++;
                  $display("FAIL rand_result got %0h want %0h", {div_zero, res}, e);
               end
            end
         end
         if (in_valid && in_ready) begin
            q.push_back(model(x1, x2));
            issued++;
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (issued != N || q.size() != 0) begin
         errors++;
         $display("FAIL rand_drain issued %0d pending %0d want %0d and 0",
                  issued, q.size(), N);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         x1 = W'($urandom_range(1, 65535));
         x2 = W'($urandom_range(1, 255));
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_full got out_valid %b want 1", out_valid);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || res !== '0) begin
         errors++;
         $display("FAIL rstmid_clear got v %b res %0h want 0 0", out_valid, res);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stale cycle %0d got %b want 0", c, out_valid);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
